// File: rtl/vector_cache_pkg.sv
// Shared types for the vector cache row fabric: node payload layout and port ids.
package vector_cache_pkg;

    localparam int unsigned COL_ID_W = 4;
    localparam int unsigned ROW_ID_W = 4;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned TXN_ID_W = 8;
    localparam int unsigned PORT_NUM = 3;

    typedef struct packed {
        logic [DATA_W-1:0] data;
    } data_pld_t;

    typedef struct packed {
        logic [COL_ID_W-1:0] dest_col;
        logic [ROW_ID_W-1:0] dest_row;
        data_pld_t           body;
        logic [TXN_ID_W-1:0] txn_id;
    } node_pld_t;

    // Port ids double as input source ids and output destination ids.
    typedef enum logic [1:0] {
        PORT_W = 2'd0,
        PORT_E = 2'd1,
        PORT_L = 2'd2
    } port_t;

    function automatic port_t port_next(input port_t p);
        return (p == PORT_L) ? PORT_W : port_t'(p + 2'd1);
    endfunction

endpackage

// File: rtl/node_out_fifo.sv
// Per-(lane, output) payload FIFO; full is taken from the registered count only.
module node_out_fifo
    import vector_cache_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_vld,
    input  node_pld_t push_pld,
    output logic      full,
    input  logic      pop_rdy,
    output logic      out_vld,
    output node_pld_t out_pld
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    node_pld_t     mem [DEPTH];
    logic          push_ok;
    logic          pop_ok;

    assign full    = (cnt == CNT_FULL);
    assign out_vld = (cnt != '0);
    assign out_pld = mem[rd_ptr];
    assign push_ok = push_vld & ~full;
    assign pop_ok  = out_vld & pop_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_pld;
    end

endmodule

// File: rtl/param_bank_node.sv
// Row router node: per-lane decode of west/east/local inputs, round-robin arbitration
// into one FIFO per (lane, output), and a saturating count of dropped illegal payloads.
module param_bank_node
    import vector_cache_pkg::*;
#(
    parameter int unsigned CH_NUM     = 8,
    parameter int unsigned COL_NUM    = 4,
    parameter int unsigned COL_ID     = 0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CH_NUM-1:0] w_in_vld,
    input  node_pld_t         w_in_pld [CH_NUM],
    output logic [CH_NUM-1:0] w_in_rdy,
    input  logic [CH_NUM-1:0] e_in_vld,
    input  node_pld_t         e_in_pld [CH_NUM],
    output logic [CH_NUM-1:0] e_in_rdy,
    input  logic [CH_NUM-1:0] l_in_vld,
    input  node_pld_t         l_in_pld [CH_NUM],
    output logic [CH_NUM-1:0] l_in_rdy,
    output logic [CH_NUM-1:0] w_out_vld,
    output node_pld_t         w_out_pld [CH_NUM],
    input  logic [CH_NUM-1:0] w_out_rdy,
    output logic [CH_NUM-1:0] e_out_vld,
    output node_pld_t         e_out_pld [CH_NUM],
    input  logic [CH_NUM-1:0] e_out_rdy,
    output logic [CH_NUM-1:0] l_out_vld,
    output node_pld_t         l_out_pld [CH_NUM],
    input  logic [CH_NUM-1:0] l_out_rdy,
    output logic [15:0]       err_cnt,
    output logic              err_vld
);

    localparam int unsigned DROP_N   = PORT_NUM * CH_NUM;
    localparam int unsigned DW       = $clog2(DROP_N + 1);
    localparam logic [COL_ID_W:0] COL_NUM_L = (COL_ID_W+1)'(COL_NUM);
    localparam logic [COL_ID_W:0] COL_ID_L  = (COL_ID_W+1)'(COL_ID);

    logic [DROP_N-1:0] drop_vec;

    for (genvar ch = 0; ch < CH_NUM; ch++) begin : g_lane
        logic [PORT_NUM-1:0] vld;
        node_pld_t           pld [PORT_NUM];
        logic [PORT_NUM-1:0] illegal;
        port_t               tgt [PORT_NUM];
        logic [PORT_NUM-1:0] gnt_ok [PORT_NUM];
        logic [PORT_NUM-1:0] rdy;
        logic [PORT_NUM-1:0] out_rdy;
        logic [PORT_NUM-1:0] out_vld;
        node_pld_t           out_pld [PORT_NUM];

        assign vld     = {l_in_vld[ch], e_in_vld[ch], w_in_vld[ch]};
        assign pld[0]  = w_in_pld[ch];
        assign pld[1]  = e_in_pld[ch];
        assign pld[2]  = l_in_pld[ch];
        assign out_rdy = {l_out_rdy[ch], e_out_rdy[ch], w_out_rdy[ch]};

        // A west input can only travel east or stop here, and vice versa.
        always_comb begin
            logic [COL_ID_W:0] dest;
            for (int unsigned i = 0; i < PORT_NUM; i++) begin
                dest       = {1'b0, pld[i].dest_col};
                illegal[i] = (dest >= COL_NUM_L);
                if (i == 0) illegal[i] = illegal[i] | (dest < COL_ID_L);
                if (i == 1) illegal[i] = illegal[i] | (dest > COL_ID_L);
                if (dest == COL_ID_L)     tgt[i] = PORT_L;
                else if (dest > COL_ID_L) tgt[i] = PORT_E;
                else                      tgt[i] = PORT_W;
            end
        end

        always_comb begin
            for (int unsigned i = 0; i < PORT_NUM; i++) begin
                rdy[i] = rst_n & (illegal[i] | gnt_ok[0][i] | gnt_ok[1][i] | gnt_ok[2][i]);
            end
        end

        assign w_in_rdy[ch] = rdy[0];
        assign e_in_rdy[ch] = rdy[1];
        assign l_in_rdy[ch] = rdy[2];
        assign drop_vec[ch*PORT_NUM +: PORT_NUM] = vld & illegal;

        for (genvar o = 0; o < PORT_NUM; o++) begin : g_out
            logic [PORT_NUM-1:0] req;
            logic [PORT_NUM-1:0] gnt;
            port_t               ptr;
            port_t               win;
            logic                push_vld;
            logic                full;
            node_pld_t           push_pld;

            // Scan from the pointer; the first legal requester aimed here wins.
            always_comb begin
                logic              found;
                int unsigned       idx;
                logic [1:0]        idx2;
                req   = '0;
                gnt   = '0;
                win   = ptr;
                found = 1'b0;
                for (int unsigned i = 0; i < PORT_NUM; i++) begin
                    req[i] = vld[i] & ~illegal[i] & (tgt[i] == port_t'(o));
                end
                for (int unsigned k = 0; k < PORT_NUM; k++) begin
                    idx  = (int'(ptr) + k) % PORT_NUM;
                    idx2 = idx[1:0];
                    if (!found && req[idx2]) begin
                        found     = 1'b1;
                        gnt[idx2] = 1'b1;
                        win       = port_t'(idx2);
                    end
                end
                push_vld = |req;
                push_pld = pld[win];
            end

            assign gnt_ok[o] = gnt & {PORT_NUM{~full}};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)                ptr <= PORT_W;
                else if (push_vld && !full) ptr <= port_next(win);
            end

            node_out_fifo #(
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk      (clk),
                .rst_n    (rst_n),
                .push_vld (push_vld),
                .push_pld (push_pld),
                .full     (full),
                .pop_rdy  (out_rdy[o]),
                .out_vld  (out_vld[o]),
                .out_pld  (out_pld[o])
            );
        end

        assign w_out_vld[ch] = out_vld[0];
        assign e_out_vld[ch] = out_vld[1];
        assign l_out_vld[ch] = out_vld[2];
        assign w_out_pld[ch] = out_pld[0];
        assign e_out_pld[ch] = out_pld[1];
        assign l_out_pld[ch] = out_pld[2];
    end

    logic [DW-1:0]   drop_n;
    logic [16+DW:0]  err_sum;

    always_comb begin
        drop_n = '0;
        for (int unsigned i = 0; i < DROP_N; i++) begin
            drop_n = drop_n + {{(DW-1){1'b0}}, drop_vec[i]};
        end
        err_sum = {{(DW+1){1'b0}}, err_cnt} + {{17{1'b0}}, drop_n};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
            err_vld <= 1'b0;
        end else if (|drop_vec) begin
            err_cnt <= (err_sum > (17+DW)'(16'hFFFF)) ? 16'hFFFF : err_sum[15:0];
            err_vld <= 1'b1;
        end
    end

endmodule

// File: tb/tb_param_bank_node.sv
// Directed bench for param_bank_node at COL_ID=1, COL_NUM=4, FIFO_DEPTH=4, CH_NUM=8.
module tb_param_bank_node;
    import vector_cache_pkg::*;

    localparam int unsigned CH = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CH-1:0] w_in_vld, e_in_vld, l_in_vld;
    logic [CH-1:0] w_in_rdy, e_in_rdy, l_in_rdy;
    node_pld_t     w_in_pld [CH];
    node_pld_t     e_in_pld [CH];
    node_pld_t     l_in_pld [CH];
    logic [CH-1:0] w_out_vld, e_out_vld, l_out_vld;
    logic [CH-1:0] w_out_rdy, e_out_rdy, l_out_rdy;
    node_pld_t     w_out_pld [CH];
    node_pld_t     e_out_pld [CH];
    node_pld_t     l_out_pld [CH];
    logic [15:0]   err_cnt;
    logic          err_vld;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    param_bank_node #(
        .CH_NUM     (CH),
        .COL_NUM    (4),
        .COL_ID     (1),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .w_in_vld  (w_in_vld),
        .w_in_pld  (w_in_pld),
        .w_in_rdy  (w_in_rdy),
        .e_in_vld  (e_in_vld),
        .e_in_pld  (e_in_pld),
        .e_in_rdy  (e_in_rdy),
        .l_in_vld  (l_in_vld),
        .l_in_pld  (l_in_pld),
        .l_in_rdy  (l_in_rdy),
        .w_out_vld (w_out_vld),
        .w_out_pld (w_out_pld),
        .w_out_rdy (w_out_rdy),
        .e_out_vld (e_out_vld),
        .e_out_pld (e_out_pld),
        .e_out_rdy (e_out_rdy),
        .l_out_vld (l_out_vld),
        .l_out_pld (l_out_pld),
        .l_out_rdy (l_out_rdy),
        .err_cnt   (err_cnt),
        .err_vld   (err_vld)
    );

    function automatic node_pld_t mk(input logic [3:0] col, input logic [7:0] txn);
        node_pld_t p;
        p.dest_col  = col;
        p.dest_row  = 4'h0;
        p.body.data = {24'hA5A5A5, txn};
        p.txn_id    = txn;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        w_in_vld = '0;
        e_in_vld = '0;
        l_in_vld = '0;
        for (int i = 0; i < CH; i++) begin
            w_in_pld[i] = mk(4'd1, 8'h00);
            e_in_pld[i] = mk(4'd1, 8'h00);
            l_in_pld[i] = mk(4'd1, 8'h00);
        end
        w_out_rdy = '1;
        e_out_rdy = '1;
        l_out_rdy = '1;
    endtask

    initial begin
        node_pld_t   exp_p;
        int unsigned wn, ln, acc;

        // reset: ready held low even with legal traffic offered
        rst_n = 1'b0;
        clear_inputs();
        l_in_vld = '1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_l_rdy", l_in_rdy, 0);
        chk("rst_w_rdy", w_in_rdy, 0);
        chk("rst_e_out_vld", e_out_vld, 0);
        chk("rst_l_out_vld", l_out_vld, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_err_vld", err_vld, 0);
        clear_inputs();
        #2 rst_n = 1'b1;
        step();

        // routing: local -> east, west -> local, one cycle latency
        l_in_vld[0] = 1'b1;
        l_in_pld[0] = mk(4'd3, 8'h11);
        #1 chk("route_l_rdy", l_in_rdy[0], 1);
        step();
        l_in_vld[0] = 1'b0;
        chk("route_e_vld", e_out_vld, 8'h01);
        chk("route_e_pld", e_out_pld[0], mk(4'd3, 8'h11));
        chk("route_l_vld_none", l_out_vld, 0);
        step();
        chk("route_e_drained", e_out_vld, 0);
        w_in_vld[0] = 1'b1;
        w_in_pld[0] = mk(4'd1, 8'h12);
        #1 chk("route_w_rdy", w_in_rdy[0], 1);
        step();
        w_in_vld[0] = 1'b0;
        chk("route_l_out_vld", l_out_vld, 8'h01);
        chk("route_l_out_pld", l_out_pld[0], mk(4'd1, 8'h12));
        step();

        // contention on lane 2 e_out: grants alternate w,l,w,l...
        wn = 0;
        ln = 0;
        for (int k = 0; k < 8; k++) begin
            w_in_vld[2] = 1'b1;
            w_in_pld[2] = mk(4'd2, 8'h20 + 8'(wn));
            l_in_vld[2] = 1'b1;
            l_in_pld[2] = mk(4'd3, 8'h40 + 8'(ln));
            #1;
            chk("arb_w_rdy", w_in_rdy[2], (k % 2 == 0) ? 1 : 0);
            chk("arb_l_rdy", l_in_rdy[2], (k % 2 == 1) ? 1 : 0);
            exp_p = (k % 2 == 0) ? mk(4'd2, 8'h20 + 8'(wn)) : mk(4'd3, 8'h40 + 8'(ln));
            step();
            chk("arb_e_vld", e_out_vld[2], 1);
            chk("arb_e_pld", e_out_pld[2], exp_p);
            if (k % 2 == 0) wn++;
            else            ln++;
        end
        w_in_vld[2] = 1'b0;
        l_in_vld[2] = 1'b0;
        step();
        chk("arb_e_drained", e_out_vld[2], 0);

        // backpressure on lane 1 e_out: only 4 of 6 offered pushes fit
        e_out_rdy[1] = 1'b0;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            l_in_vld[1] = 1'b1;
            l_in_pld[1] = mk(4'd2, 8'h60 + 8'(acc));
            #1 chk("bp_l_rdy", l_in_rdy[1], (k < 4) ? 1 : 0);
            step();
            if (k < 4) acc++;
        end
        chk("bp_head_vld", e_out_vld[1], 1);
        chk("bp_head_stable", e_out_pld[1], mk(4'd2, 8'h60));
        // full FIFO popping this cycle still refuses the push
        e_out_rdy[1] = 1'b1;
        #1 chk("full_pop_rdy", l_in_rdy[1], 0);
        step();
        chk("full_pop_head", e_out_pld[1], mk(4'd2, 8'h61));
        chk("full_next_rdy", l_in_rdy[1], 1);
        step();
        chk("drain_head2", e_out_pld[1], mk(4'd2, 8'h62));
        l_in_pld[1] = mk(4'd2, 8'h65);
        #1 chk("drain_rdy_65", l_in_rdy[1], 1);
        step();
        l_in_vld[1] = 1'b0;
        chk("drain_head3", e_out_pld[1], mk(4'd2, 8'h63));
        step();
        chk("drain_head4", e_out_pld[1], mk(4'd2, 8'h64));
        step();
        chk("drain_head5", e_out_pld[1], mk(4'd2, 8'h65));
        step();
        chk("drain_empty", e_out_vld[1], 0);

        // illegal: east U-turn plus out-of-range local in one cycle
        e_in_vld[3] = 1'b1;
        e_in_pld[3] = mk(4'd3, 8'h70);
        l_in_vld[3] = 1'b1;
        l_in_pld[3] = mk(4'd5, 8'h71);
        #1;
        chk("ill_e_rdy", e_in_rdy[3], 1);
        chk("ill_l_rdy", l_in_rdy[3], 1);
        step();
        e_in_vld[3] = 1'b0;
        l_in_vld[3] = 1'b0;
        chk("ill_err_cnt", err_cnt, 16'd2);
        chk("ill_err_vld", err_vld, 1);
        chk("ill_no_w_out", w_out_vld, 0);
        chk("ill_no_e_out", e_out_vld, 0);
        chk("ill_no_l_out", l_out_vld, 0);
        w_in_vld[3] = 1'b1;
        w_in_pld[3] = mk(4'd0, 8'h72);
        step();
        w_in_vld[3] = 1'b0;
        chk("ill_w_uturn_cnt", err_cnt, 16'd3);

        // reset mid-operation with 3 entries buffered on lane 4
        e_out_rdy[4] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            l_in_vld[4] = 1'b1;
            l_in_pld[4] = mk(4'd2, 8'h80 + 8'(k));
            step();
        end
        l_in_vld[4] = 1'b0;
        chk("mid_buffered", e_out_vld[4], 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", e_out_vld, 0);
        chk("mid_rst_err", err_cnt, 0);
        chk("mid_rst_err_vld", err_vld, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        clear_inputs();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post_rst_no_stale", e_out_vld, 0);
        end
        chk("post_rst_err", err_cnt, 0);

        // saturation: 24 drops per cycle for 2730 cycles = 0xFFF0
        for (int i = 0; i < CH; i++) begin
            w_in_pld[i] = mk(4'd15, 8'h90);
            e_in_pld[i] = mk(4'd15, 8'h91);
            l_in_pld[i] = mk(4'd15, 8'h92);
        end
        w_in_vld = '1;
        e_in_vld = '1;
        l_in_vld = '1;
        repeat (2730) @(posedge clk);
        #1 chk("sat_fff0", err_cnt, 16'hFFF0);
        w_in_vld = 8'h7F;
        e_in_vld = 8'h7F;
        l_in_vld = '0;
        step();
        chk("sat_fffe", err_cnt, 16'hFFFE);
        w_in_vld = 8'h07;
        e_in_vld = '0;
        step();
        chk("sat_ffff", err_cnt, 16'hFFFF);
        w_in_vld = '1;
        e_in_vld = '1;
        l_in_vld = '1;
        step();
        chk("sat_hold", err_cnt, 16'hFFFF);
        chk("sat_err_vld", err_vld, 1);
        clear_inputs();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
